ant_world: RTL and testbench
============================

Name: ant_world

Overview:
- Downstream stage of the ant controller: consumes its `move` command and owns the ant's physical state.
- Physical state is the grid position, the heading, the step count and the escape/timeout status.
- Regenerates the sensor inputs the controller reads: `ant_l`, `ant_r`, `hit`, `escape` and, optionally, pheromone.
- The maze is a per-cell wall-mask memory loaded through a config write port.
- Closes the loop controller -> world -> controller in synthesizable RTL, replacing behavioural bench models.

Parameters:
- MAZE_W, 8, grid width in cells
- MAZE_H, 8, grid height in cells
- XW, 3, x coordinate width (clog2 MAZE_W)
- YW, 3, y coordinate width (clog2 MAZE_H)
- START_X, 0, x after reset
- START_Y, 0, y after reset
- START_DIR, 0, heading after reset (0=N,1=E,2=S,3=W)
- EXIT_X, 7, exit cell x
- EXIT_Y, 7, exit cell y
- STEP_W, 10, step counter width
- STEP_LIMIT, 1000, accepted-move budget

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- move  in  2  command from ant controller, encoded with the shared HALT/RIGHT/LEFT/FORWARD codes
- cfg_we  in  1  wall-map write strobe
- cfg_addr  in  XW+YW  cell address {y,x}
- cfg_wdata  in  4  wall mask: bit0 N, bit1 E, bit2 S, bit3 W (1 = wall)
- ant_l  out  1  wall on the ant's left side of its current cell
- ant_r  out  1  wall directly ahead of the ant
- hit  out  1  one-cycle pulse: previous FORWARD was blocked
- escape  out  1  sticky: ant reached the exit cell
- timeout  out  1  sticky: step budget exhausted
- pos_x  out  XW  current x
- pos_y  out  YW  current y
- heading  out  2  current heading
- step_cnt  out  STEP_W  accepted non-HALT moves

Behaviour:
- Reset (async assert, sync release):
  - pos = (START_X, START_Y), heading = START_DIR.
  - step_cnt = 0; hit, escape and timeout = 0.
  - Wall-map contents are not reset.
- Command sampling and status:
  - `move` is sampled on every rising clk edge, and position/heading update on that same edge.
  - `ant_l` and `ant_r` are combinational from the registered pos/heading and the wall map, so they are valid the cycle after a move.
  - `hit` is registered.
  - Status registers: RUN, DONE_ESC (escape=1), DONE_TO (timeout=1). Every command is ignored in DONE_*: no state change, no step count.
- Commands in RUN:
  - HALT: no change. step_cnt does not increment.
  - LEFT: heading = heading-1 mod 4. RIGHT: heading = heading+1 mod 4. Both increment step_cnt.
  - FORWARD: if the current-cell mask bit for the heading is set, or the move would leave the grid, position holds, hit=1 next cycle and step_cnt increments. Otherwise pos steps one cell (N: y-1, E: x+1, S: y+1, W: x-1) and step_cnt increments.
- `hit` is 0 in every cycle not following a blocked FORWARD.
- Sensors: `ant_r` = mask[heading]; `ant_l` = mask[(heading+3) mod 4].
  - The grid border always reads as a wall, whatever the mask says.
- Escape: when a FORWARD lands on (EXIT_X, EXIT_Y), escape=1 from the next cycle and stays set until reset.
- Timeout: when step_cnt reaches STEP_LIMIT it saturates and timeout=1 from the same cycle.
  - If the limit-reaching move also lands on the exit, both flags set.
- Config port:
  - A write takes effect on the next edge.
  - A write to the current cell in the same cycle as FORWARD: the move evaluates the old mask.
  - Writes are accepted in every state. No neighbour-consistency check is made; the host writes both sides of each wall.
- Reset mid-move: the async clear wins and the pending command is dropped.
- Undefined `move` codes cannot exist (2-bit, all four codes used).

Optional Feature:
- Macro: ANT_WORLD_PHEROMONE_EN.
- Enabled:
  - Adds input ph_drop[`PH_WIDTH-1:0] and output ph_detected[`PH_WIDTH-1:0].
  - Adds a per-cell pheromone array, cleared to 0 on reset.
  - On each RUN edge with ph_drop != 0, the array writes ph_drop into the current (pre-move) cell; same-edge moves still apply.
  - ph_detected = array[current cell], combinational.
  - In DONE_* drops are ignored.
- Disabled: both ports and the array are absent. Sensors and timing are otherwise identical.

Decomposition:
- Shared header/package holds:
  - move codes HALT/RIGHT/LEFT/FORWARD (shared with the controller);
  - direction codes N/E/S/W;
  - wall-mask bit indices;
  - PH_WIDTH.
- Sub-module ant_wall_map: MAZE_W*MAZE_H x 4 register array, one sync write port, one async read port addressed by the current cell.

Test Plan:
- Reset with START=(0,0,E), all masks 0 -> pos (0,0), heading 1, ant_l=1 (north border), ant_r=0, step_cnt 0, flags 0.
- FORWARD x3 then LEFT, open maze -> pos (3,0), heading N, ant_r=1 (border), step_cnt 4.
- Mask[cell(1,1)] = 4'b0010, ant at (1,1) facing E, FORWARD -> pos unchanged, hit=1 for exactly one cycle, step_cnt +1.
- Path to (7,7), then FORWARD -> escape=1 next cycle; further RIGHT/FORWARD -> pos, heading and step_cnt frozen.
- STEP_LIMIT=4, issue RIGHT x6 -> step_cnt saturates at 4, timeout=1, heading changes only 4 times.
- With ANT_WORLD_PHEROMONE_EN: drop 1 at (0,0), move E, move W -> ph_detected 0 at (1,0), 1 back at (0,0); rst_n pulse mid-run -> ph_detected 0 everywhere.

Source files
------------

// File: rtl/ant_world_pkg.sv
// ant_world_pkg: move, direction and wall-mask codes shared by the ant controller and world.
// PH_WIDTH sizes the pheromone ports when ANT_WORLD_PHEROMONE_EN is defined.
`ifndef PH_WIDTH
`define PH_WIDTH 2
`endif
package ant_world_pkg;

    typedef enum logic [1:0] {
        HALT    = 2'd0,
        RIGHT   = 2'd1,
        LEFT    = 2'd2,
        FORWARD = 2'd3
    } move_t;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_E = 2'd1,
        DIR_S = 2'd2,
        DIR_W = 2'd3
    } dir_t;

    // Mask bit index equals the direction code, so mask[heading] is "ahead".
    localparam int WALL_N = 0;
    localparam int WALL_E = 1;
    localparam int WALL_S = 2;
    localparam int WALL_W = 3;

    localparam int PH_WIDTH = `PH_WIDTH;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DONE_ESC = 2'd1,
        ST_DONE_TO  = 2'd2
    } status_t;

endpackage

// File: rtl/ant_wall_map.sv
// ant_wall_map: per-cell 4-bit wall masks, one sync write port, one async read port.
module ant_wall_map #(
    parameter int XW = 3,
    parameter int YW = 3
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [XW+YW-1:0]     i_waddr,
    input  logic [3:0]           i_wdata,
    input  logic [XW+YW-1:0]     i_raddr,
    output logic [3:0]           o_rdata
);
    localparam int DEPTH = 1 << (XW + YW);

    logic [3:0] r_mem [DEPTH];

    // Maze contents survive reset; the host reloads them explicitly.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ant_world.sv
// ant_world: owns the ant's position, heading, step count and status; regenerates its sensors.
// Optional pheromone array enabled by defining ANT_WORLD_PHEROMONE_EN.
module ant_world
    import ant_world_pkg::*;
#(
    parameter int MAZE_W     = 8,
    parameter int MAZE_H     = 8,
    parameter int XW         = 3,
    parameter int YW         = 3,
    parameter int START_X    = 0,
    parameter int START_Y    = 0,
    parameter int START_DIR  = 0,
    parameter int EXIT_X     = 7,
    parameter int EXIT_Y     = 7,
    parameter int STEP_W     = 10,
    parameter int STEP_LIMIT = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            move,
    input  logic                  cfg_we,
    input  logic [XW+YW-1:0]      cfg_addr,
    input  logic [3:0]            cfg_wdata,
`ifdef ANT_WORLD_PHEROMONE_EN
    input  logic [`PH_WIDTH-1:0]  ph_drop,
    output logic [`PH_WIDTH-1:0]  ph_detected,
`endif
    output logic                  ant_l,
    output logic                  ant_r,
    output logic                  hit,
    output logic                  escape,
    output logic                  timeout,
    output logic [XW-1:0]         pos_x,
    output logic [YW-1:0]         pos_y,
    output logic [1:0]            heading,
    output logic [STEP_W-1:0]     step_cnt
);
    logic [XW-1:0]     r_x;
    logic [YW-1:0]     r_y;
    logic [1:0]        r_dir;
    logic [STEP_W-1:0] r_step;
    logic              r_hit;
    status_t           r_state;

    logic [XW-1:0]     w_x_nx;
    logic [YW-1:0]     w_y_nx;
    logic [1:0]        w_dir_nx;
    logic [STEP_W-1:0] w_step_nx;
    logic              w_hit_nx;
    logic              w_moved;
    status_t           w_state_nx;

    logic [XW+YW-1:0]  w_cell;
    logic [3:0]        w_mask;
    logic [3:0]        w_edge;
    logic [3:0]        w_wall;
    logic              w_run;
    move_t             w_move;

    assign w_cell = {r_y, r_x};
    assign w_move = move_t'(move);
    assign w_run  = (r_state == ST_RUN);

    ant_wall_map #(
        .XW(XW),
        .YW(YW)
    ) u_map (
        .clk     (clk),
        .i_we    (cfg_we),
        .i_waddr (cfg_addr),
        .i_wdata (cfg_wdata),
        .i_raddr (w_cell),
        .o_rdata (w_mask)
    );

    // The grid border reads as a wall regardless of the stored mask.
    assign w_edge[WALL_N] = (r_y == '0);
    assign w_edge[WALL_E] = (r_x == XW'(MAZE_W - 1));
    assign w_edge[WALL_S] = (r_y == YW'(MAZE_H - 1));
    assign w_edge[WALL_W] = (r_x == '0);
    assign w_wall         = w_mask | w_edge;

    assign ant_r = w_wall[r_dir];
    assign ant_l = w_wall[r_dir - 2'd1];

    always_comb begin
        w_x_nx    = r_x;
        w_y_nx    = r_y;
        w_dir_nx  = r_dir;
        w_step_nx = r_step;
        w_hit_nx  = 1'b0;
        w_moved   = 1'b0;
        if (w_run) begin
            unique case (w_move)
                HALT: ;
                RIGHT: begin
                    w_dir_nx  = r_dir + 2'd1;
                    w_step_nx = r_step + 1'b1;
                end
                LEFT: begin
                    w_dir_nx  = r_dir - 2'd1;
                    w_step_nx = r_step + 1'b1;
                end
                FORWARD: begin
                    w_step_nx = r_step + 1'b1;
                    if (w_wall[r_dir]) begin
                        w_hit_nx = 1'b1;
                    end else begin
                        w_moved = 1'b1;
                        unique case (r_dir)
                            DIR_N: w_y_nx = r_y - 1'b1;
                            DIR_E: w_x_nx = r_x + 1'b1;
                            DIR_S: w_y_nx = r_y + 1'b1;
                            DIR_W: w_x_nx = r_x - 1'b1;
                        endcase
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_state_nx = r_state;
        if (w_run) begin
            if (w_moved && w_x_nx == XW'(EXIT_X) && w_y_nx == YW'(EXIT_Y))
                w_state_nx = ST_DONE_ESC;
            else if (w_step_nx == STEP_W'(STEP_LIMIT))
                w_state_nx = ST_DONE_TO;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x     <= XW'(START_X);
            r_y     <= YW'(START_Y);
            r_dir   <= 2'(START_DIR);
            r_step  <= '0;
            r_hit   <= 1'b0;
            r_state <= ST_RUN;
        end else begin
            r_x     <= w_x_nx;
            r_y     <= w_y_nx;
            r_dir   <= w_dir_nx;
            r_step  <= w_step_nx;
            r_hit   <= w_hit_nx;
            r_state <= w_state_nx;
        end
    end

`ifdef ANT_WORLD_PHEROMONE_EN
    localparam int PH_DEPTH = 1 << (XW + YW);

    logic [`PH_WIDTH-1:0] r_ph [PH_DEPTH];

    // Drops mark the cell the ant occupies before this edge's move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PH_DEPTH; i++) r_ph[i] <= '0;
        end else if (w_run && ph_drop != '0) begin
            r_ph[w_cell] <= ph_drop;
        end
    end

    assign ph_detected = r_ph[w_cell];
`endif

    assign hit      = r_hit;
    assign escape   = (r_state == ST_DONE_ESC);
    assign timeout  = (r_step == STEP_W'(STEP_LIMIT));
    assign pos_x    = r_x;
    assign pos_y    = r_y;
    assign heading  = r_dir;
    assign step_cnt = r_step;

endmodule

// File: tb/tb_ant_world.sv
// tb_ant_world: random and directed stimulus against a grid-walk reference model.
module tb_ant_world;

    localparam logic [1:0] M_HALT  = 2'd0;
    localparam logic [1:0] M_RIGHT = 2'd1;
    localparam logic [1:0] M_LEFT  = 2'd2;
    localparam logic [1:0] M_FWD   = 2'd3;
    localparam int LIMIT = 1000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] move = 2'd0;
    logic       cfg_we = 1'b0;
    logic [5:0] cfg_addr = 6'd0;
    logic [3:0] cfg_wdata = 4'd0;
    logic       ant_l, ant_r, hit, escape, timeout;
    logic [2:0] pos_x, pos_y;
    logic [1:0] heading;
    logic [9:0] step_cnt;

    int errors = 0;
    int checks = 0;

    int mx, my, md, ms;
    bit mesc, mhit;
    logic [3:0] mwall [64];

    wire [22:0] w_obs = {ant_l, ant_r, hit, escape, timeout,
                         pos_x, pos_y, heading, step_cnt};

    ant_world #(
        .START_DIR  (1),
        .STEP_LIMIT (LIMIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .move      (move),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .ant_l     (ant_l),
        .ant_r     (ant_r),
        .hit       (hit),
        .escape    (escape),
        .timeout   (timeout),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .heading   (heading),
        .step_cnt  (step_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit m_blk(int d);
        bit b;
        b = mwall[my * 8 + mx][d];
        case (d)
            0:       b = b | (my == 0);
            1:       b = b | (mx == 7);
            2:       b = b | (my == 7);
            default: b = b | (mx == 0);
        endcase
        return b;
    endfunction

    function automatic logic [22:0] exp_vec();
        return {m_blk((md + 3) % 4), m_blk(md), mhit, mesc, (ms == LIMIT),
                3'(mx), 3'(my), 2'(md), 10'(ms)};
    endfunction

    task automatic model_edge(input logic [1:0] mv, input bit we,
                              input logic [5:0] a, input logic [3:0] d);
        mhit = 0;
        if (!mesc && ms < LIMIT) begin
            case (mv)
                M_RIGHT: begin md = (md + 1) % 4; ms++; end
                M_LEFT:  begin md = (md + 3) % 4; ms++; end
                M_FWD: begin
                    ms++;
                    if (m_blk(md)) begin
                        mhit = 1;
                    end else begin
                        case (md)
                            0:       my = my - 1;
                            1:       mx = mx + 1;
                            2:       my = my + 1;
                            default: mx = mx - 1;
                        endcase
                        if (mx == 7 && my == 7) mesc = 1;
                    end
                end
                default: ;
            endcase
        end
        if (we) mwall[a] = d;
    endtask

    task automatic cyc(input logic [1:0] mv, input bit we = 0,
                       input logic [5:0] a = 6'd0, input logic [3:0] d = 4'd0);
        @(negedge clk);
        move = mv; cfg_we = we; cfg_addr = a; cfg_wdata = d;
        @(posedge clk);
        model_edge(mv, we, a, d);
        #1;
        move = M_HALT; cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; move = M_HALT; cfg_we = 1'b0;
        #2;
        mx = 0; my = 0; md = 1; ms = 0; mesc = 0; mhit = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_open();
        for (int i = 0; i < 64; i++) cyc(M_HALT, 1, 6'(i), 4'd0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (w_obs !== {1'b1, 1'b0, 3'b000, 3'd0, 3'd0, 2'd1, 10'd0}) begin
            errors++;
            $display("FAIL reset obs=%h exp=%h", w_obs,
                     {1'b1, 1'b0, 3'b000, 3'd0, 3'd0, 2'd1, 10'd0});
        end
        checks++;
        if (w_obs !== exp_vec()) begin
            errors++;
            $display("FAIL reset_model obs=%h exp=%h", w_obs, exp_vec());
        end
    endtask

    task automatic test_forward_left();
        logic [1:0] seq [4];
        seq = '{M_FWD, M_FWD, M_FWD, M_LEFT};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(seq[i]);
            checks++;
            if (w_obs !== exp_vec()) begin
                errors++;
                $display("FAIL fwd_left[%0d] obs=%h exp=%h", i, w_obs, exp_vec());
            end
        end
        checks++;
        if ({pos_x, pos_y, heading, ant_r, step_cnt} !== {3'd3, 3'd0, 2'd0, 1'b1, 10'd4}) begin
            errors++;
            $display("FAIL fwd_left_end x=%0d y=%0d h=%0d r=%0d s=%0d need 3 0 0 1 4",
                     pos_x, pos_y, heading, ant_r, step_cnt);
        end
    endtask

    task automatic test_hit();
        logic [1:0] seq [6];
        seq = '{M_FWD, M_RIGHT, M_FWD, M_LEFT, M_FWD, M_HALT};
        do_reset();
        cyc(M_HALT, 1, 6'd9, 4'b0010);
        for (int i = 0; i < 6; i++) begin
            cyc(seq[i]);
            checks++;
            if (w_obs !== exp_vec()) begin
                errors++;
                $display("FAIL hit_seq[%0d] obs=%h exp=%h", i, w_obs, exp_vec());
            end
            if (i == 4) begin
                checks++;
                if ({hit, pos_x, pos_y, step_cnt} !== {1'b1, 3'd1, 3'd1, 10'd5}) begin
                    errors++;
                    $display("FAIL hit_pulse hit=%0d x=%0d y=%0d s=%0d need 1 1 1 5",
                             hit, pos_x, pos_y, step_cnt);
                end
            end
        end
        checks++;
        if (hit !== 1'b0) begin
            errors++;
            $display("FAIL hit_clear hit=%0d need 0", hit);
        end
        cyc(M_HALT, 1, 6'd9, 4'd0);
    endtask

    task automatic test_escape();
        do_reset();
        for (int i = 0; i < 15; i++) begin
            cyc(i == 7 ? M_RIGHT : M_FWD);
            checks++;
            if (w_obs !== exp_vec()) begin
                errors++;
                $display("FAIL esc_path[%0d] obs=%h exp=%h", i, w_obs, exp_vec());
            end
        end
        cyc(M_RIGHT);
        cyc(M_FWD);
        cyc(M_LEFT);
        checks++;
        if ({escape, pos_x, pos_y, heading, step_cnt} !== {1'b1, 3'd7, 3'd7, 2'd2, 10'd15}) begin
            errors++;
            $display("FAIL esc_frozen e=%0d x=%0d y=%0d h=%0d s=%0d need 1 7 7 2 15",
                     escape, pos_x, pos_y, heading, step_cnt);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < LIMIT + 2; i++) begin
            cyc(M_RIGHT);
            checks++;
            if (w_obs !== exp_vec()) begin
                errors++;
                $display("FAIL to_seq[%0d] obs=%h exp=%h", i, w_obs, exp_vec());
            end
        end
        checks++;
        if ({timeout, escape, step_cnt, heading} !== {1'b1, 1'b0, 10'(LIMIT), 2'd1}) begin
            errors++;
            $display("FAIL to_end t=%0d e=%0d s=%0d h=%0d need 1 0 %0d 1",
                     timeout, escape, step_cnt, heading, LIMIT);
        end
    endtask

    task automatic test_cfg_same_cycle();
        do_reset();
        cyc(M_FWD, 1, 6'd0, 4'b0010);
        checks++;
        if ({pos_x, hit, step_cnt} !== {3'd1, 1'b0, 10'd1}) begin
            errors++;
            $display("FAIL cfg_old_mask x=%0d hit=%0d s=%0d need 1 0 1",
                     pos_x, hit, step_cnt);
        end
        cyc(M_LEFT);
        cyc(M_LEFT);
        cyc(M_FWD);
        checks++;
        if (w_obs !== exp_vec()) begin
            errors++;
            $display("FAIL cfg_back obs=%h exp=%h", w_obs, exp_vec());
        end
        cyc(M_HALT, 1, 6'd0, 4'd0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        cyc(M_FWD);
        cyc(M_FWD);
        @(negedge clk);
        move = M_FWD;
        #2 rst_n = 1'b0;
        #1;
        mx = 0; my = 0; md = 1; ms = 0; mesc = 0; mhit = 0;
        checks++;
        if ({pos_x, pos_y, heading, step_cnt} !== {3'd0, 3'd0, 2'd1, 10'd0}) begin
            errors++;
            $display("FAIL async_clear x=%0d y=%0d h=%0d s=%0d need 0 0 1 0",
                     pos_x, pos_y, heading, step_cnt);
        end
        @(negedge clk);
        move = M_HALT;
        rst_n = 1'b1;
        cyc(M_HALT);
        checks++;
        if (w_obs !== exp_vec()) begin
            errors++;
            $display("FAIL reset_drop obs=%h exp=%h", w_obs, exp_vec());
        end
    endtask

    task automatic test_random();
        logic [1:0] mv;
        bit         we;
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int i = 0; i < 64; i++) cyc(M_HALT, 1, 6'(i), 4'($urandom));
            for (int i = 0; i < 250; i++) begin
                mv = ($urandom % 3 == 0) ? 2'($urandom) : M_FWD;
                we = ($urandom % 8 == 0);
                cyc(mv, we, 6'($urandom), 4'($urandom));
                checks++;
                if (w_obs !== exp_vec()) begin
                    errors++;
                    $display("FAIL rand[%0d.%0d] obs=%h exp=%h", r, i, w_obs, exp_vec());
                end
            end
        end
        load_open();
    endtask

    initial begin
        do_reset();
        load_open();
        test_reset();
        test_forward_left();
        test_hit();
        test_escape();
        test_cfg_same_cycle();
        test_reset_mid();
        test_random();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
